// File: rtl/core_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch front end.
package core_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 64;
    localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Instruction addresses are always word aligned.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_queue_stage_if.sv
// Fetch-stage signal bundle: redirect, instruction-memory handshake and decode-side queue head.
interface fetch_queue_stage_if;

    logic                         redirect_valid;
    logic [core_pkg::ADDR_W-1:0]  redirect_pc;

    logic                         imem_req_valid;
    logic                         imem_req_ready;
    logic [core_pkg::ADDR_W-1:0]  imem_req_addr;
    logic                         imem_resp_valid;
    logic [core_pkg::INSTR_W-1:0] imem_resp_data;

    logic                         if_valid;
    logic                         if_ready;
    logic [core_pkg::INSTR_W-1:0] if_instr;
    logic [core_pkg::ADDR_W-1:0]  if_pc;
    logic [core_pkg::ADDR_W-1:0]  if_pc_plus4;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        input  if_ready,
        output imem_req_valid, imem_req_addr,
        output if_valid, if_instr, if_pc, if_pc_plus4
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        output if_ready,
        input  imem_req_valid, imem_req_addr,
        input  if_valid, if_instr, if_pc, if_pc_plus4
    );

endinterface

// File: rtl/fetch_queue_stage_fifo.sv
// Prefetch queue of {pc, instr} entries; flush empties it and wins over push/pop.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           din,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Entry storage is data only; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_stage.sv
// LEGv8 fetch front end: owns the fetch PC, issues one word request at a time and
// queues returned instructions with their PCs for decode.
module fetch_queue_stage
    import core_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input logic                 clk,
    input logic                 reset,
    fetch_queue_stage_if.master fq
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic              outstanding;
    logic              drop;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    used;
    fetch_entry_t      head;
    fetch_entry_t      resp_entry;
    logic              credit_ok;
    logic              req_valid;
    logic              req_fire;
    logic              resp_hit;
    logic              push;
    logic              pop;
    logic              if_valid;

    // The in-flight request already owns a queue slot, so a push can never overflow.
    assign used      = {1'b0, count} + {{CNT_W{1'b0}}, outstanding};
    assign credit_ok = used < (CNT_W + 1)'(DEPTH);

    assign req_valid = !reset && !outstanding && credit_ok && !fq.redirect_valid;
    assign req_fire  = req_valid && fq.imem_req_ready;
    assign resp_hit  = fq.imem_resp_valid && outstanding;
    assign push      = resp_hit && !drop && !fq.redirect_valid;
    assign if_valid  = (count != '0);
    assign pop       = if_valid && fq.if_ready;

    assign resp_entry.pc    = req_pc;
    assign resp_entry.instr = fq.imem_resp_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end else if (fq.redirect_valid) begin
            fetch_pc <= word_align(fq.redirect_pc);
            if (outstanding) begin
                // A response landing with the redirect is simply discarded;
                // otherwise remember to discard it when it shows up.
                if (fq.imem_resp_valid) begin
                    outstanding <= 1'b0;
                    drop        <= 1'b0;
                end else begin
                    drop <= 1'b1;
                end
            end
        end else if (req_fire) begin
            outstanding <= 1'b1;
            fetch_pc    <= fetch_pc + PC_INC;
        end else if (resp_hit) begin
            outstanding <= 1'b0;
            drop        <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            req_pc <= fetch_pc;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (fq.redirect_valid),
        .din   (resp_entry),
        .head  (head),
        .count (count)
    );

    assign fq.imem_req_valid = req_valid;
    assign fq.imem_req_addr  = fetch_pc;
    assign fq.if_valid       = if_valid;
    assign fq.if_instr       = head.instr;
    assign fq.if_pc          = head.pc;
    assign fq.if_pc_plus4    = head.pc + PC_INC;

endmodule
